// File: rtl/captouch_pkg.sv
// captouch_pkg: shared FSM state encoding and default parameter values for the touch TX driver.
package captouch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} captouch_tx_state_t;
  localparam int DEF_N_TX        = 4;
  localparam int DEF_HALF_PERIOD = 8;
  localparam int DEF_PULSES      = 16;
  localparam int DEF_SETTLE      = 3;
  localparam int DEF_GAP         = 4;
endpackage

// File: rtl/captouch_timer.sv
// captouch_timer: loadable down-counter with terminal-count flag, times pulse halves and row gaps.
// Ports: clk, reset (async, active-high), load/load_val (reload), count (current value), tc (count == 0).
module captouch_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         tc
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - W'(1);
  assign tc = count == '0;
endmodule

// File: rtl/captouch_tx_driver.sv
// captouch_tx_driver: scans N_TX electrodes, driving each with a pulse burst and a settled sample strobe.
// Ports: clk, reset (async, active-high), start/continuous/abort controls; tx_out/tx_oe electrode drive,
// sample strobe, row index, row_done/scan_done strobes, busy. All outputs are registered.
// Define CAPTOUCH_TX_TRISTATE_EN to float non-active electrodes (tx_oe one-hot on row while busy).
module captouch_tx_driver
  import captouch_pkg::*;
#(
  parameter int N_TX        = DEF_N_TX,
  parameter int HALF_PERIOD = DEF_HALF_PERIOD,
  parameter int PULSES      = DEF_PULSES,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int GAP         = DEF_GAP,
  localparam int RW = N_TX > 1 ? $clog2(N_TX) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            continuous,
  input  logic            abort,
  output logic [N_TX-1:0] tx_out,
  output logic [N_TX-1:0] tx_oe,
  output logic            sample,
  output logic [RW-1:0]   row,
  output logic            row_done,
  output logic            scan_done,
  output logic            busy
);
  localparam int PW   = PULSES > 1 ? $clog2(PULSES) : 1;
  localparam int MAXT = HALF_PERIOD > GAP ? HALF_PERIOD : GAP;
  localparam int TW   = $clog2(MAXT);
  captouch_tx_state_t state, state_n;
  logic [PW-1:0]   pulse, pulse_n;
  logic [RW-1:0]   row_n;
  logic [N_TX-1:0] sel_n, tx_out_n;
  logic            sample_n, row_done_n, scan_done_n, busy_n, load, tc;
  logic [TW-1:0]   cnt, load_val;
  captouch_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .count    (cnt),
    .tc       (tc)
  );
  always_comb begin
    state_n = state;
    pulse_n = pulse;
    row_n   = row;
    if (abort) state_n = S_IDLE;
    else
      case (state)
        S_IDLE: if (start) begin
          state_n = S_HIGH;
          pulse_n = '0;
          row_n   = '0;
        end
        S_HIGH: if (tc) state_n = S_LOW;
        S_LOW: if (tc) begin
          state_n = pulse == PW'(PULSES - 1) ? S_GAP : S_HIGH;
          pulse_n = pulse == PW'(PULSES - 1) ? pulse : pulse + PW'(1);
        end
        S_GAP: if (tc) begin
          state_n = row != RW'(N_TX - 1) || continuous ? S_HIGH : S_IDLE;
          row_n   = row == RW'(N_TX - 1) ? '0 : row + RW'(1);
          pulse_n = '0;
        end
        default: state_n = S_IDLE;
      endcase
    // Every phase boundary is a state change, so the timer reloads exactly on transitions.
    load     = state_n != state && state_n != S_IDLE;
    load_val = state_n == S_GAP ? TW'(GAP - 1) : TW'(HALF_PERIOD - 1);
    sel_n        = '0;
    sel_n[row_n] = 1'b1;
    tx_out_n     = state_n == S_HIGH ? sel_n : '0;
    // Strobe is registered, so it is decided one count early; SETTLE==0 fires on HIGH entry.
    sample_n     = state_n == S_HIGH &&
                   (state != S_HIGH ? SETTLE == 0 : SETTLE != 0 && cnt == TW'(HALF_PERIOD - SETTLE));
    row_done_n   = state_n == S_GAP && state != S_GAP;
    scan_done_n  = row_done_n && row == RW'(N_TX - 1);
    busy_n       = state_n != S_IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= S_IDLE;
      pulse     <= '0;
      row       <= '0;
      tx_out    <= '0;
      sample    <= 1'b0;
      row_done  <= 1'b0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      pulse     <= pulse_n;
      row       <= row_n;
      tx_out    <= tx_out_n;
      sample    <= sample_n;
      row_done  <= row_done_n;
      scan_done <= scan_done_n;
      busy      <= busy_n;
    end
`ifdef CAPTOUCH_TX_TRISTATE_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) tx_oe <= '0;
    else tx_oe <= busy_n ? sel_n : '0;
`else
  assign tx_oe = '1;
`endif
endmodule
